rct_entropy_buffer: RTL and testbench

- Health-test and collection stage between the raw entropy sampler and the SHA-256 conditioner.
- Runs the Repetition Count Test (RCT) on every raw sample bit. Discards the partial block on failure.
- Packs passing bits MSB-first into a 448-bit message block. Hands the block to the hash stage through a valid/ready handshake.

---
 rtl/rct_entropy_buffer.sv | 133 +++++++++++++
 tb/tb_rct_entropy_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/rct_entropy_buffer.sv
// rtl/rct_entropy_buffer.sv - RCT health test and MSB-first message block packer
//
// Runs the Repetition Count Test on every valid raw sample, packs passing
// samples MSB-first into a BLOCK_BITS message block and offers the completed
// block to the hash stage through a valid/ready handshake.
//
// Ports:
//   TRNG_Clock    single rising-edge clock
//   TRNG_Reset    synchronous active-high reset
//   sample_bit    raw entropy bit
//   sample_valid  sample_bit valid this cycle
//   block_data    message block, first accepted bit at the MSB
//   block_valid   block_data complete and stable
//   block_ready   hash stage accepts the block when high with block_valid
//   failure       RCT failure level
//   sample_drop   one-cycle pulse when a valid sample was not stored
//   fill_level    number of bits currently stored
module rct_entropy_buffer #(
    parameter int BLOCK_BITS = 448,
    parameter int RCT_CUTOFF = 32,
    parameter int FILL_W     = 9,
    parameter int RUN_W      = 6
) (
    input  logic                  TRNG_Clock,
    input  logic                  TRNG_Reset,
    input  logic                  sample_bit,
    input  logic                  sample_valid,
    output logic [BLOCK_BITS-1:0] block_data,
    output logic                  block_valid,
    input  logic                  block_ready,
    output logic                  failure,
    output logic                  sample_drop,
    output logic [FILL_W-1:0]     fill_level
);

    typedef enum logic {
        ST_FILL,
        ST_HOLD
    } state_t;

    state_t                state_q;
    logic [BLOCK_BITS-1:0] data_q;
    logic                  valid_q;
    logic                  failure_q;
    logic                  drop_q;
    logic [FILL_W-1:0]     fill_q;
    logic [RUN_W-1:0]      run_q;
    logic                  last_bit_q;

    logic [RUN_W-1:0]      run_d;
    logic                  rct_fail_d;
    logic [FILL_W-1:0]     fill_inc;

    // Run counter update. run_q == 0 only before the first sample after
    // reset, so that sample always starts a fresh run regardless of the
    // reset value of last_bit_q. The counter saturates at the cutoff.
    always_comb begin
        run_d = run_q;
        if (sample_valid) begin
            if (run_q == '0 || sample_bit != last_bit_q) begin
                run_d = RUN_W'(1);
            end else if (run_q == RUN_W'(RCT_CUTOFF)) begin
                run_d = run_q;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    assign rct_fail_d = (run_d == RUN_W'(RCT_CUTOFF));
    assign fill_inc   = fill_q + FILL_W'(1);

    always_ff @(posedge TRNG_Clock) begin
        if (TRNG_Reset) begin
            state_q    <= ST_FILL;
            data_q     <= '0;
            valid_q    <= 1'b0;
            failure_q  <= 1'b0;
            drop_q     <= 1'b0;
            fill_q     <= '0;
            run_q      <= '0;
            last_bit_q <= 1'b0;
        end else begin
            drop_q <= 1'b0;
            // run_d equals run_q when no sample arrives, so failure holds.
            failure_q <= rct_fail_d;
            if (sample_valid) begin
                run_q      <= run_d;
                last_bit_q <= sample_bit;
            end

            case (state_q)
                ST_FILL: begin
                    if (sample_valid) begin
                        if (rct_fail_d) begin
                            // Discard the partial block; data_q is left as is.
                            fill_q <= '0;
                            drop_q <= 1'b1;
                        end else begin
                            data_q <= {data_q[BLOCK_BITS-2:0], sample_bit};
                            fill_q <= fill_inc;
                            if (fill_inc == FILL_W'(BLOCK_BITS)) begin
                                valid_q <= 1'b1;
                                state_q <= ST_HOLD;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    // Block is frozen; RCT keeps running, samples are dropped.
                    if (sample_valid) begin
                        drop_q <= 1'b1;
                    end
                    if (valid_q && block_ready) begin
                        valid_q <= 1'b0;
                        fill_q  <= '0;
                        state_q <= ST_FILL;
                    end
                end
                default: begin
                    state_q <= ST_FILL;
                end
            endcase
        end
    end

    assign block_data  = data_q;
    assign block_valid = valid_q;
    assign failure     = failure_q;
    assign sample_drop = drop_q;
    assign fill_level  = fill_q;

endmodule

// File: tb/tb_rct_entropy_buffer.sv
// tb/tb_rct_entropy_buffer.sv - directed self-checking bench for rct_entropy_buffer
module tb_rct_entropy_buffer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    // Small instance: BLOCK_BITS=8, RCT_CUTOFF=4
    logic       s_bit = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready = 1'b0;
    logic [7:0] s_data;
    logic       s_bvalid;
    logic       s_fail;
    logic       s_drop;
    logic [3:0] s_fill;

    // Default instance: BLOCK_BITS=448, RCT_CUTOFF=32
    logic         d_bit = 1'b0;
    logic         d_valid = 1'b0;
    logic         d_ready = 1'b0;
    logic [447:0] d_data;
    logic         d_bvalid;
    logic         d_fail;
    logic         d_drop;
    logic [8:0]   d_fill;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rct_entropy_buffer #(
        .BLOCK_BITS(8),
        .RCT_CUTOFF(4),
        .FILL_W    (4),
        .RUN_W     (3)
    ) u_small (
        .TRNG_Clock  (clk),
        .TRNG_Reset  (rst),
        .sample_bit  (s_bit),
        .sample_valid(s_valid),
        .block_data  (s_data),
        .block_valid (s_bvalid),
        .block_ready (s_ready),
        .failure     (s_fail),
        .sample_drop (s_drop),
        .fill_level  (s_fill)
    );

    rct_entropy_buffer u_dflt (
        .TRNG_Clock  (clk),
        .TRNG_Reset  (rst),
        .sample_bit  (d_bit),
        .sample_valid(d_valid),
        .block_data  (d_data),
        .block_valid (d_bvalid),
        .block_ready (d_ready),
        .failure     (d_fail),
        .sample_drop (d_drop),
        .fill_level  (d_fill)
    );

    task automatic chk(input string tag, input logic [447:0] obs, input logic [447:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s mismatched", tag);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed_s(input logic b);
        s_bit   = b;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic feed_d(input logic b);
        d_bit   = b;
        d_valid = 1'b1;
        tick();
        d_valid = 1'b0;
    endtask

    initial begin
        logic [7:0]   seq8;
        logic [7:0]   t3_bits;
        logic [7:0]   t3_fail;
        logic [31:0]  t3_fill;
        logic [6:0]   t4_bits;
        logic [6:0]   t4_fail;
        logic [27:0]  t4_fill;
        logic [447:0] alt;
        logic [3:0]   ef;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        chk("rst_data",  448'(s_data), 448'(0));
        chk("rst_valid", 448'(s_bvalid), 448'(0));
        chk("rst_fail",  448'(s_fail), 448'(0));
        chk("rst_drop",  448'(s_drop), 448'(0));
        chk("rst_fill",  448'(s_fill), 448'(0));
        chk("rst_dfill", 448'(d_fill), 448'(0));
        rst = 1'b0;

        // T1: 1,0,1,1,0,0,1,0 -> 8'hB2
        seq8 = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) begin
            feed_s(seq8[i]);
            chk("t1_valid", 448'(s_bvalid), 448'(i == 0));
            chk("t1_drop",  448'(s_drop), 448'(0));
            chk("t1_fill",  448'(s_fill), 448'(8 - i));
        end
        chk("t1_data", 448'(s_data), 448'(8'hB2));
        chk("t1_fail", 448'(s_fail), 448'(0));
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_hold_data",  448'(s_data), 448'(8'hB2));
            chk("t1_hold_valid", 448'(s_bvalid), 448'(1));
        end

        // T2: three samples while holding are dropped, then handshake
        seq8 = 8'b0000_0101;
        for (int i = 2; i >= 0; i--) begin
            feed_s(seq8[i]);
            chk("t2_drop",  448'(s_drop), 448'(1));
            chk("t2_data",  448'(s_data), 448'(8'hB2));
            chk("t2_valid", 448'(s_bvalid), 448'(1));
            chk("t2_fill",  448'(s_fill), 448'(8));
        end
        s_ready = 1'b1;
        tick();
        s_ready = 1'b0;
        chk("t2_hs_valid", 448'(s_bvalid), 448'(0));
        chk("t2_hs_fill",  448'(s_fill), 448'(0));
        chk("t2_hs_drop",  448'(s_drop), 448'(0));

        // T3: last stored bit was 1; 1,0,1 then 1,1,1,1 then 0
        t3_bits = 8'b1011_1110;
        t3_fail = 8'b0000_0110;
        t3_fill = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd1};
        for (int i = 7; i >= 0; i--) begin
            feed_s(t3_bits[i]);
            ef = t3_fill[i*4 +: 4];
            chk("t3_fail", 448'(s_fail), 448'(t3_fail[i]));
            chk("t3_drop", 448'(s_drop), 448'(t3_fail[i]));
            chk("t3_fill", 448'(s_fill), 448'(ef));
        end

        // T4: 1 then six 0s; failure from the 4th 0 onward, run saturated
        t4_bits = 7'b100_0000;
        t4_fail = 7'b000_0111;
        t4_fill = {4'd2, 4'd3, 4'd4, 4'd5, 4'd0, 4'd0, 4'd0};
        for (int i = 6; i >= 0; i--) begin
            feed_s(t4_bits[i]);
            ef = t4_fill[i*4 +: 4];
            chk("t4_fail", 448'(s_fail), 448'(t4_fail[i]));
            chk("t4_drop", 448'(s_drop), 448'(t4_fail[i]));
            chk("t4_fill", 448'(s_fill), 448'(ef));
        end
        tick();
        chk("t4_fail_level", 448'(s_fail), 448'(1));
        chk("t4_drop_pulse", 448'(s_drop), 448'(0));

        // T6: reset overrides a pending handshake
        seq8 = 8'b1010_0110;
        for (int i = 7; i >= 0; i--) begin
            feed_s(seq8[i]);
        end
        chk("t6_pre_valid", 448'(s_bvalid), 448'(1));
        chk("t6_pre_data",  448'(s_data), 448'(8'hA6));
        chk("t6_pre_fail",  448'(s_fail), 448'(0));
        rst     = 1'b1;
        s_ready = 1'b1;
        tick();
        rst     = 1'b0;
        s_ready = 1'b0;
        chk("t6_data",  448'(s_data), 448'(0));
        chk("t6_valid", 448'(s_bvalid), 448'(0));
        chk("t6_fail",  448'(s_fail), 448'(0));
        chk("t6_drop",  448'(s_drop), 448'(0));
        chk("t6_fill",  448'(s_fill), 448'(0));
        seq8 = 8'b0110_1001;
        for (int i = 7; i >= 0; i--) begin
            feed_s(seq8[i]);
            chk("t6_refill_valid", 448'(s_bvalid), 448'(i == 0));
        end
        chk("t6_refill_data", 448'(s_data), 448'(8'h69));
        chk("t6_refill_fill", 448'(s_fill), 448'(8));

        // T5: default parameters, 448-bit alternating stream starting with 0
        for (int i = 0; i < 448; i++) begin
            feed_d(i[0]);
            chk("t5_fail",  448'(d_fail), 448'(0));
            chk("t5_valid", 448'(d_bvalid), 448'(i == 447));
        end
        alt = {224{2'b01}};
        chk("t5_data", d_data, alt);
        chk("t5_msb",  448'(d_data[447]), 448'(0));
        chk("t5_lsb",  448'(d_data[0]), 448'(1));
        chk("t5_fill", 448'(d_fill), 448'(448));
        chk("t5_drop", 448'(d_drop), 448'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
